// File: rtl/prng_seed_loader.sv
// Seed loader for the 128-bit LFSR PRNG: streams seed words into the feed port,
// then releases the lock and pulses pre_rst. Optional macro: PRNG_SEED_ZERO_CHECK_EN.
module prng_seed_loader #(
    parameter int SIZE_FEED = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SIZE_FEED-1:0] seed_in_data,
    input  logic                 seed_in_valid,
    output logic                 seed_in_ready,
    input  logic                 reseed_req,
    output logic                 prng_feed,
    output logic [SIZE_FEED-1:0] prng_feed_data,
    output logic                 prng_lock_feed,
    output logic                 prng_pre_rst,
    output logic                 seeded,
    output logic                 seed_err
);

    localparam int NWORDS = 128 / SIZE_FEED;
    localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        LOAD,
        DRAIN,
        SETTLE,
        RSTP,
        READY,
        ERR
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WCNT_W-1:0] wcnt;
    logic              hs;
    logic              last;
    logic              zero;

    assign seed_in_ready = (state == LOAD);
    assign hs            = seed_in_valid & seed_in_ready;
    assign last          = hs && (wcnt == WCNT_W'(NWORDS - 1));
    assign seeded        = (state == READY);

`ifdef PRNG_SEED_ZERO_CHECK_EN
    logic [SIZE_FEED-1:0] acc;

    assign zero     = (acc == '0);
    assign seed_err = (state == ERR);

    // OR of every word of the current load; an all-zero LFSR state locks up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (state != LOAD && state_nx == LOAD) begin
            acc <= '0;
        end else if (hs) begin
            acc <= acc | seed_in_data;
        end
    end
`else
    assign zero     = 1'b0;
    assign seed_err = 1'b0;
`endif

    // Next-state: load words, drain last pulse, unlock, reset PRNG, run
    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    if (last) state_nx = DRAIN;
            DRAIN:   state_nx = zero ? ERR : SETTLE;
            SETTLE:  state_nx = RSTP;
            RSTP:    state_nx = READY;
            READY:   if (reseed_req) state_nx = LOAD;
            ERR:     if (reseed_req) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // State, word counter and registered PRNG controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOAD;
            wcnt           <= '0;
            prng_feed      <= 1'b0;
            prng_feed_data <= '0;
            prng_lock_feed <= 1'b1;
            prng_pre_rst   <= 1'b0;
        end else begin
            state          <= state_nx;
            prng_feed      <= hs;
            if (hs) begin
                prng_feed_data <= seed_in_data;
                wcnt           <= last ? '0 : wcnt + WCNT_W'(1);
            end
            prng_lock_feed <= (state_nx == LOAD) ||
                              (state_nx == DRAIN) ||
                              (state_nx == ERR);
            prng_pre_rst   <= (state_nx == RSTP);
        end
    end

endmodule

// File: tb/tb_prng_seed_loader.sv
// Randomized bench for prng_seed_loader against a timing-rule reference model.
// Covers SIZE_FEED=32 (main) and SIZE_FEED=128 (directed single word).
module tb_prng_seed_loader;

    localparam int NW = 4;
`ifdef PRNG_SEED_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seed_data = '0;
    logic        seed_valid = 1'b0;
    logic        seed_ready;
    logic        reseed = 1'b0;
    logic        feed;
    logic [31:0] feed_data;
    logic        lock;
    logic        pre_rst;
    logic        seeded;
    logic        seed_err;

    logic [127:0] w_data = '0;
    logic         w_valid = 1'b0;
    logic         w_ready;
    logic         w_reseed = 1'b0;
    logic         w_feed;
    logic [127:0] w_feed_data;
    logic         w_lock;
    logic         w_pre;
    logic         w_seeded;
    logic         w_err;

    int n_vec = 0;
    int n_err = 0;

    // reference model: words taken this load, edges since the final word
    bit          m_load;
    int          m_cnt;
    logic [31:0] m_acc;
    int          m_since;
    bit          m_err;
    bit          m_feed;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    prng_seed_loader #(.SIZE_FEED(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .seed_in_data   (seed_data),
        .seed_in_valid  (seed_valid),
        .seed_in_ready  (seed_ready),
        .reseed_req     (reseed),
        .prng_feed      (feed),
        .prng_feed_data (feed_data),
        .prng_lock_feed (lock),
        .prng_pre_rst   (pre_rst),
        .seeded         (seeded),
        .seed_err       (seed_err)
    );

    prng_seed_loader #(.SIZE_FEED(128)) dut128 (
        .clk            (clk),
        .rst_n          (rst_n),
        .seed_in_data   (w_data),
        .seed_in_valid  (w_valid),
        .seed_in_ready  (w_ready),
        .reseed_req     (w_reseed),
        .prng_feed      (w_feed),
        .prng_feed_data (w_feed_data),
        .prng_lock_feed (w_lock),
        .prng_pre_rst   (w_pre),
        .seeded         (w_seeded),
        .seed_err       (w_err)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load  = 1'b1;
        m_cnt   = 0;
        m_acc   = '0;
        m_since = -1;
        m_err   = 1'b0;
        m_feed  = 1'b0;
        m_data  = '0;
    endtask

    task automatic check_all();
        chk("seed_in_ready", seed_ready, m_load);
        chk("prng_feed", feed, m_feed);
        chk("prng_feed_data", feed_data, m_data);
        chk("prng_lock_feed", lock, m_load || m_since == 0 || m_err);
        chk("prng_pre_rst", pre_rst, !m_load && m_since == 2 && !m_err);
        chk("seeded", seeded, !m_load && m_since >= 3 && !m_err);
        chk("seed_err", seed_err, m_err);
    endtask

    // one clock: drive at negedge, advance model at posedge, check #1 later
    task automatic cyc(input bit v, input logic [31:0] d, input bit rs);
        bit hs;
        seed_valid = v;
        seed_data  = d;
        reseed     = rs;
        #1;
        chk("seed_in_ready_pre", seed_ready, m_load);
        @(posedge clk);
        hs     = v && m_load;
        m_feed = hs;
        if (hs) m_data = d;
        if (m_load) begin
            if (hs) begin
                m_acc = m_acc | d;
                m_cnt++;
                if (m_cnt == NW) begin
                    m_load  = 1'b0;
                    m_since = 0;
                end
            end
        end else if (rs && (m_since >= 3 || m_err)) begin
            m_load  = 1'b1;
            m_cnt   = 0;
            m_acc   = '0;
            m_since = -1;
            m_err   = 1'b0;
        end else if (!m_err && m_since < 3) begin
            m_since++;
            if (m_since == 1 && ZC && m_acc == 0) m_err = 1'b1;
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic load4(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input int gap);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, w[i], 1'b0);
            for (int g = 0; g < gap; g++) cyc(1'b0, $urandom, 1'b0);
        end
        for (int k = 0; k < 5; k++) cyc(1'b0, $urandom, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        // basic back-to-back load
        load4(32'h1, 32'h2, 32'h3, 32'h4, 0);
        // reseed from READY, then gapped reload
        cyc(1'b0, '0, 1'b1);
        load4($urandom, $urandom, $urandom, $urandom | 1, 2);

        // all-zero seed
        cyc(1'b0, '0, 1'b1);
        load4('0, '0, '0, '0, 0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);

        // async reset after two words
        cyc(1'b1, 32'hA5A5_0001, 1'b0);
        cyc(1'b1, 32'hA5A5_0002, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h11, 1'b0);
        cyc(1'b1, 32'h22, 1'b0);
        cyc(1'b0, '0, 1'b0);
        load4(32'h33, 32'h44, 32'h55, 32'h66, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            cyc($urandom_range(0, 2) != 0, d, $urandom_range(0, 5) == 0);
        end

        // 128-bit build: single word fills the seed
        chk("w_ready", w_ready, 1'b1);
        w_valid = 1'b1;
        w_data  = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        chk("w_feed", w_feed, 1'b1);
        chk("w_feed_data", w_feed_data,
            128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);
        chk("w_lock_drain", w_lock, 1'b1);
        chk("w_ready_drain", w_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("w_feed_off", w_feed, 1'b0);
        chk("w_lock_settle", w_lock, 1'b0);
        chk("w_pre_settle", w_pre, 1'b0);
        @(posedge clk);
        #1;
        chk("w_pre_rstp", w_pre, 1'b1);
        chk("w_seeded_rstp", w_seeded, 1'b0);
        @(posedge clk);
        #1;
        chk("w_pre_ready", w_pre, 1'b0);
        chk("w_seeded", w_seeded, 1'b1);
        chk("w_err", w_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
